// File: rtl/mod_mult.sv
// Bit-serial MSB-first modular multiplier: (a * b) mod m.
// Interleaved double-and-add, one multiplier bit per clock.
module mod_mult #(
    parameter int SIZE = 65
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [SIZE-1:0] input_a_tdata,
    input  logic            input_a_tvalid,
    output logic            input_a_tready,
    input  logic [SIZE-1:0] input_b_tdata,
    input  logic            input_b_tvalid,
    output logic            input_b_tready,
    input  logic [SIZE-1:0] input_modulus_tdata,
    input  logic            input_modulus_tvalid,
    output logic            input_modulus_tready,
    output logic [SIZE-1:0] output_tdata,
    output logic            output_tvalid,
    input  logic            output_tready
);

    localparam int IW = $clog2(SIZE);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t          state, state_nx;
    logic [SIZE-1:0] a_q, b_q, m_q, acc_q, res_q;
    logic [IW-1:0]   idx_q;
    logic            in_ready, accept, last;

    logic [SIZE:0]   dbl, dbl_r, sum, sum_r;
    logic [SIZE:0]   m_w, b_w;
    logic [SIZE-1:0] acc_nx;
    logic            m_small;

    assign in_ready = (state == IDLE);
    assign accept   = in_ready & input_a_tvalid & input_b_tvalid
                    & input_modulus_tvalid;
    assign last     = (idx_q == '0);

    assign input_a_tready       = in_ready;
    assign input_b_tready       = in_ready;
    assign input_modulus_tready = in_ready;
    assign output_tdata         = res_q;
    assign output_tvalid        = (state == DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (accept) state_nx = CALC;
            CALC: if (last) state_nx = DONE;
            DONE: if (output_tready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // acc < m keeps both partial values below 2m, so one subtract each.
    always_comb begin
        m_w     = {1'b0, m_q};
        b_w     = {1'b0, b_q};
        m_small = (m_q[SIZE-1:1] == '0);
        dbl     = {acc_q, 1'b0};
        dbl_r   = (dbl >= m_w) ? dbl - m_w : dbl;
        sum     = a_q[idx_q] ? dbl_r + b_w : dbl_r;
        sum_r   = (sum >= m_w) ? sum - m_w : sum;
        acc_nx  = m_small ? '0 : sum_r[SIZE-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q   <= '0;
            b_q   <= '0;
            m_q   <= '0;
            acc_q <= '0;
            res_q <= '0;
            idx_q <= '0;
        end else if (accept) begin
            a_q   <= input_a_tdata;
            b_q   <= input_b_tdata;
            m_q   <= input_modulus_tdata;
            acc_q <= '0;
            idx_q <= IW'(SIZE - 1);
        end else if (state == CALC) begin
            acc_q <= acc_nx;
            if (last) begin
                res_q <= acc_nx;
            end else begin
                idx_q <= idx_q - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mod_mult.sv
// Directed bench for mod_mult: results, fixed latency, join,
// backpressure and asynchronous reset behaviour.
module tb_mod_mult;

    localparam int SIZE = 65;
    localparam int LAT  = 65;

    logic            clk = 1'b0;
    logic            rst;
    logic [SIZE-1:0] input_a_tdata, input_b_tdata, input_modulus_tdata;
    logic            input_a_tvalid, input_b_tvalid, input_modulus_tvalid;
    logic            input_a_tready, input_b_tready, input_modulus_tready;
    logic [SIZE-1:0] output_tdata;
    logic            output_tvalid;
    logic            output_tready;

    int total = 0;
    int fails = 0;
    int lat;
    logic [SIZE-1:0] big_m, ga, inv;

    mod_mult #(.SIZE(SIZE)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .input_a_tdata        (input_a_tdata),
        .input_a_tvalid       (input_a_tvalid),
        .input_a_tready       (input_a_tready),
        .input_b_tdata        (input_b_tdata),
        .input_b_tvalid       (input_b_tvalid),
        .input_b_tready       (input_b_tready),
        .input_modulus_tdata  (input_modulus_tdata),
        .input_modulus_tvalid (input_modulus_tvalid),
        .input_modulus_tready (input_modulus_tready),
        .output_tdata         (output_tdata),
        .output_tvalid        (output_tvalid),
        .output_tready        (output_tready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [SIZE-1:0] obs,
                         input logic [SIZE-1:0] exp);
        total++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Modular inverse by extended Euclid, coefficients kept mod m.
    function automatic logic [SIZE-1:0] mod_inv(input logic [SIZE-1:0] x,
                                                input logic [SIZE-1:0] m);
        logic [129:0] r0, r1, t0, t1, q, tmp, mm;
        mm = {65'd0, m};
        r0 = mm;
        r1 = {65'd0, x};
        t0 = '0;
        t1 = 130'd1;
        for (int k = 0; k < 200 && r1 != 0; k++) begin
            q   = r0 / r1;
            tmp = r0 - q * r1;
            r0  = r1;
            r1  = tmp;
            tmp = (t0 + mm - (q * t1) % mm) % mm;
            t0  = t1;
            t1  = tmp;
        end
        return t0[SIZE-1:0];
    endfunction

    task automatic send(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b,
                        input logic [SIZE-1:0] m);
        @(negedge clk);
        input_a_tdata        = a;
        input_b_tdata        = b;
        input_modulus_tdata  = m;
        input_a_tvalid       = 1'b1;
        input_b_tvalid       = 1'b1;
        input_modulus_tvalid = 1'b1;
        @(posedge clk);
        #1;
        input_a_tvalid       = 1'b0;
        input_b_tvalid       = 1'b0;
        input_modulus_tvalid = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!output_tvalid && n < 200);
    endtask

    task automatic run_op(input string tag, input logic [SIZE-1:0] a,
                          input logic [SIZE-1:0] b, input logic [SIZE-1:0] m,
                          input logic [SIZE-1:0] exp);
        int n;
        send(a, b, m);
        wait_valid(n);
        check({tag, "_lat"}, SIZE'(n), SIZE'(LAT));
        check({tag, "_data"}, output_tdata, exp);
        @(posedge clk);
        #1;
        check({tag, "_vld_drop"}, SIZE'(output_tvalid), SIZE'(0));
        check({tag, "_rdy"}, SIZE'(input_a_tready), SIZE'(1));
    endtask

    initial begin
        rst                  = 1'b0;
        output_tready        = 1'b1;
        input_a_tdata        = '0;
        input_b_tdata        = '0;
        input_modulus_tdata  = '0;
        input_a_tvalid       = 1'b0;
        input_b_tvalid       = 1'b0;
        input_modulus_tvalid = 1'b0;
        #12;
        check("rst_vld", SIZE'(output_tvalid), SIZE'(0));
        check("rst_data", output_tdata, SIZE'(0));
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rdy_a", SIZE'(input_a_tready), SIZE'(1));
        check("rdy_b", SIZE'(input_b_tready), SIZE'(1));
        check("rdy_m", SIZE'(input_modulus_tready), SIZE'(1));

        run_op("t1", 65'd3, 65'd5, 65'd7, 65'd1);

        big_m = 65'd18446744073709551337;
        run_op("t2_sq", big_m - 65'd1, big_m - 65'd1, big_m, 65'd1);
        ga  = 65'd10794478246981970827;
        inv = mod_inv(ga, big_m);
        run_op("t2_inv", ga, inv, big_m, 65'd1);

        run_op("t3_m1", 65'd0, 65'd0, 65'd1, 65'd0);
        run_op("t3_a0", 65'd0, 65'd6, 65'd7, 65'd0);
        run_op("x_66", 65'd6, 65'd6, 65'd7, 65'd1);
        run_op("x_45", 65'd4, 65'd5, 65'd7, 65'd6);
        run_op("x_big", 65'd1 << 63, 65'd2, big_m, 65'd279);

        // backpressure: result and valid hold while tready is low
        output_tready = 1'b0;
        send(65'd3, 65'd5, 65'd7);
        wait_valid(lat);
        check("t4_lat", SIZE'(lat), SIZE'(LAT));
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            check("t4_hold_vld", SIZE'(output_tvalid), SIZE'(1));
            check("t4_hold_data", output_tdata, SIZE'(1));
            check("t4_hold_rdy", SIZE'(input_b_tready), SIZE'(0));
        end
        output_tready = 1'b1;
        @(posedge clk);
        #1;
        check("t4_vld_drop", SIZE'(output_tvalid), SIZE'(0));
        check("t4_rdy", SIZE'(input_modulus_tready), SIZE'(1));

        // partial valid set is ignored until modulus arrives
        @(negedge clk);
        input_a_tdata        = 65'd3;
        input_b_tdata        = 65'd5;
        input_modulus_tdata  = 65'd7;
        input_a_tvalid       = 1'b1;
        input_b_tvalid       = 1'b1;
        input_modulus_tvalid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            check("t5_idle", SIZE'(input_a_tready), SIZE'(1));
        end
        input_modulus_tvalid = 1'b1;
        @(posedge clk);
        #1;
        check("t5_accept", SIZE'(input_a_tready), SIZE'(0));
        input_a_tvalid       = 1'b0;
        input_b_tvalid       = 1'b0;
        input_modulus_tvalid = 1'b0;
        wait_valid(lat);
        check("t5_lat", SIZE'(lat), SIZE'(LAT));
        check("t5_data", output_tdata, SIZE'(1));
        @(posedge clk);
        #1;

        // reset in the middle of CALC
        send(65'd3, 65'd5, 65'd7);
        repeat (30) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("t6_vld", SIZE'(output_tvalid), SIZE'(0));
        check("t6_rdy", SIZE'(input_a_tready), SIZE'(1));
        @(negedge clk);
        rst = 1'b1;
        run_op("t6_after", 65'd3, 65'd5, 65'd7, 65'd1);

        // reset while a result is pending in DONE
        output_tready = 1'b0;
        send(65'd4, 65'd5, 65'd7);
        wait_valid(lat);
        check("rd_vld_up", SIZE'(output_tvalid), SIZE'(1));
        rst = 1'b0;
        #1;
        check("rd_vld_drop", SIZE'(output_tvalid), SIZE'(0));
        check("rd_data", output_tdata, SIZE'(0));
        @(negedge clk);
        rst = 1'b1;
        output_tready = 1'b1;
        run_op("rd_after", 65'd6, 65'd6, 65'd7, 65'd1);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
